// File: rtl/sd_cic_sinc3.sv
// Third-order CIC (sinc3) decimator: 1-bit modulator stream in, settled 48-bit result out.
// Optional macro SD_CIC_BIPOLAR_EN selects +1/-1 input mapping with sign-extended output.
module sd_cic_sinc3 #(
    parameter int LOG2R = 6,
    parameter int W     = 3*LOG2R+2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bit_in,
    input  logic        bit_valid,
    output logic [47:0] filtered_out,
    output logic        out_valid,
    output logic        settled
);

    localparam logic [LOG2R-1:0] DCNT_LAST = '1;

    logic [W-1:0]     x;
    logic [W-1:0]     integ_reg [3];
    logic [W-1:0]     integ_next [3];
    logic [W-1:0]     dly_reg [3];
    logic [W-1:0]     comb_next [3];
    logic [W-1:0]     i3_cap_reg;
    logic [LOG2R-1:0] dcnt_reg;
    logic             pending_reg;
    logic [1:0]       warm_reg;
    logic [47:0]      ext_next;

`ifdef SD_CIC_BIPOLAR_EN
    assign x        = bit_in ? W'(1) : '1;
    assign ext_next = {{(48-W){comb_next[2][W-1]}}, comb_next[2]};
`else
    assign x        = bit_in ? W'(1) : '0;
    assign ext_next = {{(48-W){1'b0}}, comb_next[2]};
`endif

    // Integrator chain resolves in one edge; wrap modulo 2^W is cancelled by the comb.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign integ_next[gi] = integ_reg[gi] + x;
                assign comb_next[gi]  = i3_cap_reg - dly_reg[gi];
            end else begin : g_rest
                assign integ_next[gi] = integ_reg[gi] + integ_next[gi-1];
                assign comb_next[gi]  = comb_next[gi-1] - dly_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                integ_reg[i] <= '0;
                dly_reg[i]   <= '0;
            end
            i3_cap_reg   <= '0;
            dcnt_reg     <= '0;
            pending_reg  <= 1'b0;
            warm_reg     <= 2'd0;
            filtered_out <= '0;
            out_valid    <= 1'b0;
            settled      <= 1'b0;
        end else begin
            out_valid   <= 1'b0;
            pending_reg <= bit_valid && (dcnt_reg == DCNT_LAST);
            if (bit_valid) begin
                for (int i = 0; i < 3; i++) begin
                    integ_reg[i] <= integ_next[i];
                end
                dcnt_reg <= dcnt_reg + 1'b1;
                if (dcnt_reg == DCNT_LAST) begin
                    i3_cap_reg <= integ_next[2];
                end
            end
            // Comb runs on the clock after the decimation edge; first two results only prime the delays.
            if (pending_reg) begin
                dly_reg[0] <= i3_cap_reg;
                dly_reg[1] <= comb_next[0];
                dly_reg[2] <= comb_next[1];
                if (warm_reg[1]) begin
                    filtered_out <= ext_next;
                    out_valid    <= 1'b1;
                    settled      <= 1'b1;
                end
                if (warm_reg != 2'd3) begin
                    warm_reg <= warm_reg + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_cic_sinc3.sv
// Directed bench for sd_cic_sinc3: three instances (LOG2R = 2, 6, 10) share one stimulus stream.
module tb_sd_cic_sinc3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic [47:0] fo2, fo6, fo10;
    logic        ov2, ov6, ov10;
    logic        st2, st6, st10;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    sd_cic_sinc3 #(.LOG2R(2)) dut2 (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .filtered_out(fo2), .out_valid(ov2), .settled(st2)
    );
    sd_cic_sinc3 #(.LOG2R(6)) dut6 (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .filtered_out(fo6), .out_valid(ov6), .settled(st6)
    );
    sd_cic_sinc3 #(.LOG2R(10)) dut10 (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .filtered_out(fo10), .out_valid(ov10), .settled(st10)
    );

`ifdef SD_CIC_BIPOLAR_EN
    localparam logic [47:0] EXP_R4_ZERO  = 48'hFFFF_FFFF_FFC0;
    localparam logic [47:0] EXP_R64_ALT  = 48'd0;
`else
    localparam logic [47:0] EXP_R4_ZERO  = 48'd0;
    localparam logic [47:0] EXP_R64_ALT  = 48'd131072;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_state(input string tag);
        chk({tag, "_fo2"}, fo2, 48'd0);
        chk({tag, "_ov2"}, {47'd0, ov2}, 48'd0);
        chk({tag, "_st2"}, {47'd0, st2}, 48'd0);
        chk({tag, "_fo6"}, fo6, 48'd0);
        chk({tag, "_ov10"}, {47'd0, ov10}, 48'd0);
        chk({tag, "_st10"}, {47'd0, st10}, 48'd0);
    endtask

    // Reset held with bit_valid high: reset must win and drop the sample.
    task automatic do_reset();
        reset     = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        tick();
        chk_zero_state("reset");
    endtask

    // pat: 0 = constant 1, 1 = constant 0, 2 = alternating 1/0 per accepted sample.
    task automatic run(input int log2r, input int s, input int pat, input int n_edges,
                       input logic [47:0] expv);
        int r, first, per, smp;
        logic [47:0] fo;
        logic ov, st, exp_ov, exp_st;
        r     = 1 << log2r;
        first = s * (3 * r - 1) + 2;
        per   = r * s;
        smp   = 0;
        reset = 1'b0;
        for (int k = 1; k <= n_edges; k++) begin
            bit_valid = ((k - 1) % s == 0);
            bit_in    = (pat == 0) ? 1'b1 : (pat == 1) ? 1'b0 : (smp % 2 == 0);
            if (bit_valid) smp++;
            tick();
            case (log2r)
                2:       begin fo = fo2;  ov = ov2;  st = st2;  end
                6:       begin fo = fo6;  ov = ov6;  st = st6;  end
                default: begin fo = fo10; ov = ov10; st = st10; end
            endcase
            exp_st = (k >= first);
            exp_ov = (k >= first) && ((k - first) % per == 0);
            chk($sformatf("L%0d_s%0d_p%0d_ov_e%0d", log2r, s, pat, k), {47'd0, ov}, {47'd0, exp_ov});
            chk($sformatf("L%0d_s%0d_p%0d_st_e%0d", log2r, s, pat, k), {47'd0, st}, {47'd0, exp_st});
            chk($sformatf("L%0d_s%0d_p%0d_fo_e%0d", log2r, s, pat, k), fo, exp_st ? expv : 48'd0);
        end
        bit_valid = 1'b0;
    endtask

    initial begin
        // R=4 constant 1: first strobe on edge 13, value 64, every 4 clocks.
        do_reset();
        run(2, 1, 0, 21, 48'd64);

        // Same stream with bit_valid 1-of-3: strobes on edges 35 and 47.
        do_reset();
        run(2, 3, 0, 50, 48'd64);

        // Reset at E+1 (E = edge 20): strobe suppressed, settled drops, warm-up restarts.
        do_reset();
        run(2, 1, 0, 20, 48'd64);
        reset     = 1'b1;
        bit_valid = 1'b1;
        tick();
        chk("rst_e1_ov2", {47'd0, ov2}, 48'd0);
        chk("rst_e1_st2", {47'd0, st2}, 48'd0);
        chk("rst_e1_fo2", fo2, 48'd0);
        run(2, 1, 0, 18, 48'd64);

        // R=4 constant 0.
        do_reset();
        run(2, 1, 1, 18, EXP_R4_ZERO);

        // R=64 alternating: R^3/2 unipolar, 0 bipolar.
        do_reset();
        run(6, 1, 2, 260, EXP_R64_ALT);

        // R=1024 constant 1: 2^30 with integrator wrap.
        do_reset();
        run(10, 1, 0, 3075, 48'd1073741824);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sd_cic_sinc3.md
# sd_cic_sinc3

Third-order CIC (sinc3) decimation filter for the sigma-delta ADC chain. Takes the 1-bit modulator bitstream, integrates it at the modulator rate and combs it at the decimated rate. Produces the 48-bit `filtered_in` word consumed by `sd_decimation` directly downstream. Start-up transients are suppressed so the next stage sees only settled samples.

## Interface
- `LOG2R`, default 6: log2 of decimation ratio R (R = 64); legal range 1..10.
- `W`, default 3*LOG2R+2: internal integrator/comb width; derived, never overridden.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `bit_in`  in  1  modulator output bit; sampled only when `bit_valid`=1.
- `bit_valid`  in  1  modulator-rate enable; any duty cycle, may be high every cycle.
- `filtered_out`  out  48  settled sinc3 result, extended from W bits to 48; feeds `filtered_in` of `sd_decimation`.
- `out_valid`  out  1  one-cycle strobe: new `filtered_out` available.
- `settled`  out  1  high once the filter has produced its third decimated result; stays high until reset.

## Operation
- Input mapping: x = `bit_in` ? 1 : 0 (unipolar; see Configuration).
- Integrators: three W-bit registers i1, i2, i3, updated only on `bit_valid` cycles, in a single edge, non-pipelined:
  - i1' = i1 + x
  - i2' = i2 + i1'
  - i3' = i3 + i2'
- Integrator arithmetic wraps modulo 2^W by design. No saturation. Comb output is exact despite the wrap.
- Decimation counter `dcnt`, LOG2R bits:
  - Increments on each `bit_valid`.
  - The `bit_valid` edge where `dcnt`==R-1 is the decimation edge E; `dcnt` wraps to 0.
- Comb stage: at edge E+1 it uses the i3 value captured at E and the delay registers d1, d2, d3 (W bits each):
  - c1 = i3 - d1; c2 = c1 - d2; c3 = c2 - d3.
  - Then d1 <= i3, d2 <= c1, d3 <= c2.
- Warm-up counter (2 bits, saturating) counts comb results:
  - Results 1 and 2 update the comb delays only. `filtered_out` is unchanged and `out_valid` stays 0.
  - Result 3 and later load `filtered_out` <= extend(c3) and pulse `out_valid`. `settled` rises with the first `out_valid` and stays high.
- Unipolar range: 0..R^3, zero-extended to 48 bits.
- `bit_valid` gaps freeze integrators and `dcnt`. The result depends only on the sample sequence, not on its timing.

## Timing
- Reset values: `filtered_out`=0, `out_valid`=0, `settled`=0, i1..i3=0, d1..d3=0, `dcnt`=0, warm-up=0.
- Latency: the R-th sample is accepted at edge E; `filtered_out`/`out_valid` are registered at E+1; `out_valid` is high for exactly the one cycle after E+1.
- `out_valid` period is R `bit_valid` cycles; minimum spacing is R clocks.
- `filtered_out` holds between strobes.
- No back-pressure: the downstream stage must accept every strobe.
- `reset` during any cycle, including E or E+1, clears all state. Any in-flight comb result is discarded and warm-up restarts (two suppressed results).
- `reset` and `bit_valid` both high: reset wins, and the sample is dropped.

## Configuration
- `SD_CIC_BIPOLAR_EN` defined:
  - Mapping is x = `bit_in` ? +1 : -1, in signed two's complement.
  - Output range is -R^3..+R^3, sign-extended from W to 48 bits.
- `SD_CIC_BIPOLAR_EN` undefined:
  - Unipolar mapping, as in Operation.
  - Bits 47..W of `filtered_out` are always 0.

## Test plan
- LOG2R=2, unipolar, `bit_in`=1 with `bit_valid` every cycle from reset:
  - Internal comb results are 20 and 60, and both are suppressed.
  - The first `out_valid` is on clock 13 after reset release (edge E=12, +1) with `filtered_out`=64; every later strobe is 64, 4 clocks apart.
  - `settled` rises with the first strobe.
- LOG2R=2, `SD_CIC_BIPOLAR_EN`, `bit_in`=0 constant -> every strobe has `filtered_out`=48'hFFFF_FFFF_FFC0 (-64).
- LOG2R=6, unipolar, alternating 1/0 -> after settling, every strobe has `filtered_out`=131072 (R^3/2). Integrators wrap repeatedly with no effect on the result.
- LOG2R=2, `bit_in`=1, `bit_valid` toggled 1-of-3 cycles -> same output sequence as the first test, with strobes 12 clocks apart.
- `reset` asserted one cycle after a decimation edge E:
  - No `out_valid` at E+1; `settled` drops.
  - After release, the first strobe again arrives on the third decimation with value 64.
- LOG2R=10, unipolar, constant 1 -> `filtered_out`=2^30. No overflow into bit W-1 and beyond.
